// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: host-side access port of the VDP.
// Decodes CPU strobes into VRAM, register, palette and status accesses.
module vdp_cpu_port #(
    parameter int RamBits = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpuCs,
    input  logic               cpuWr,
    input  logic               cpuRd,
    input  logic [1:0]         cpuPort,
    input  logic [7:0]         cpuDataIn,
    output logic [7:0]         cpuDataOut,
    output logic               cpuWait,
    output logic               vramReq,
    output logic               vramWe,
    output logic [RamBits-1:0] vramAddr,
    output logic [7:0]         vramDataOut,
    input  logic [7:0]         vramDataIn,
    input  logic               vramGrant,
    output logic               regWe,
    output logic [2:0]         regIndex,
    output logic [7:0]         regData,
    output logic               palWe,
    output logic [5:0]         palIndex,
    output logic [7:0]         palData,
    input  logic               vblank,
    output logic               irq
);

    typedef enum logic [1:0] {
        IDLE,
        WREQ,
        RREQ,
        RWAIT
    } state_t;

    state_t state, state_nxt;

    logic [RamBits-1:0] addr;
    logic [1:0]  page;
    logic [7:0]  lo;
    logic        toggle;
    logic        pal_mode;
    logic [5:0]  pal_ptr;
    logic        flag;
    logic        irq_en;
    logic        vblank_q;
    logic [7:0]  wbuf;
    logic [7:0]  read_buf;

    logic        acc;
    logic        wr;
    logic        rd;
    logic        data_wr;
    logic        ctl_wr;
    logic        page_wr;
    logic        data_rd;
    logic        stat_rd;
    logic        ctl_cmd;
    logic [1:0]  cmd;
    logic        rise;
    logic        busy;
    logic [15:0] set_addr;

    // Only IDLE accepts accesses; a write wins over a simultaneous read.
    assign acc     = cpuCs & (cpuWr | cpuRd) & (state == IDLE);
    assign wr      = acc & cpuWr;
    assign rd      = acc & ~cpuWr;
    assign data_wr = wr & (cpuPort == 2'd0);
    assign ctl_wr  = wr & (cpuPort == 2'd1);
    assign page_wr = wr & (cpuPort == 2'd3);
    assign data_rd = rd & (cpuPort == 2'd0);
    assign stat_rd = rd & (cpuPort == 2'd2);
    assign ctl_cmd = ctl_wr & toggle;
    assign cmd     = cpuDataIn[7:6];
    assign rise    = vblank & ~vblank_q;
    assign busy    = (state != IDLE);
    assign set_addr = {page, cpuDataIn[5:0], lo};

    assign vramAddr    = addr;
    assign vramDataOut = wbuf;

    // FSM state register; reset drops any pending request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and request outputs.
    always_comb begin
        state_nxt = state;
        cpuWait   = 1'b1;
        vramReq   = 1'b0;
        vramWe    = 1'b0;
        case (state)
            IDLE: begin
                cpuWait = 1'b0;
                if (data_wr & ~pal_mode)
                    state_nxt = WREQ;
                else if (data_rd & ~pal_mode)
                    state_nxt = RREQ;
                else if (ctl_cmd & (cmd == 2'b00))
                    state_nxt = RREQ;
            end
            WREQ: begin
                vramReq = 1'b1;
                vramWe  = 1'b1;
                if (vramGrant) state_nxt = IDLE;
            end
            RREQ: begin
                vramReq = 1'b1;
                if (vramGrant) state_nxt = RWAIT;
            end
            RWAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port registers, address pointer, pulses and status flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            page       <= '0;
            lo         <= '0;
            toggle     <= 1'b0;
            pal_mode   <= 1'b0;
            pal_ptr    <= '0;
            flag       <= 1'b0;
            irq_en     <= 1'b0;
            vblank_q   <= 1'b0;
            wbuf       <= '0;
            read_buf   <= '0;
            cpuDataOut <= '0;
            regWe      <= 1'b0;
            regIndex   <= '0;
            regData    <= '0;
            palWe      <= 1'b0;
            palIndex   <= '0;
            palData    <= '0;
            irq        <= 1'b0;
        end else begin
            regWe    <= 1'b0;
            palWe    <= 1'b0;
            vblank_q <= vblank;
            irq      <= flag & irq_en;

            if (ctl_wr) begin
                if (!toggle) begin
                    lo     <= cpuDataIn;
                    toggle <= 1'b1;
                end else begin
                    toggle <= 1'b0;
                    case (cmd)
                        2'b00, 2'b01: begin
                            addr     <= RamBits'(set_addr);
                            pal_mode <= 1'b0;
                        end
                        2'b10: begin
                            regWe    <= 1'b1;
                            regIndex <= cpuDataIn[2:0];
                            regData  <= lo;
                            if (cpuDataIn[2:0] == 3'd1)
                                irq_en <= lo[5];
                        end
                        default: begin
                            pal_mode <= 1'b1;
                            pal_ptr  <= lo[5:0];
                        end
                    endcase
                end
            end

            if (page_wr) page <= cpuDataIn[1:0];

            if (data_wr) begin
                if (pal_mode) begin
                    palWe    <= 1'b1;
                    palIndex <= pal_ptr;
                    palData  <= cpuDataIn;
                    pal_ptr  <= pal_ptr + 6'd1;
                end else begin
                    wbuf <= cpuDataIn;
                end
            end

            if (data_rd) cpuDataOut <= read_buf;

            if (stat_rd) begin
                cpuDataOut <= {flag, busy, 6'b0};
                toggle     <= 1'b0;
            end

            // An edge coinciding with a status read leaves the flag set.
            if (rise)         flag <= 1'b1;
            else if (stat_rd) flag <= 1'b0;

            if (state == WREQ && vramGrant) addr <= addr + 1'b1;

            if (state == RWAIT) begin
                read_buf <= vramDataIn;
                addr     <= addr + 1'b1;
            end
        end
    end

endmodule
